// File: rtl/fp_norm_pack_pkg.sv
// Shared widths, flag positions and the packed single-precision layout for the
// normalize/pack pipeline. FPNORM_DENORM_EN widens the stage-1 mantissa for the denormal shifter.
package fp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int MANT_W   = 24;
  localparam int EXP_W    = 10;
  localparam int FRAC_W   = 23;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_ZERO = 0;

  // Without denormals the hidden bit is never read after stage 1, so it is not stored.
`ifdef FPNORM_DENORM_EN
  localparam int S1_MANT_W = MANT_W;
`else
  localparam int S1_MANT_W = FRAC_W;
`endif

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  function automatic fp32_t fp_pack(input logic sign, input logic [7:0] exp,
                                    input logic [FRAC_W-1:0] frac);
    fp32_t r;
    r.sign = sign;
    r.exp  = exp;
    r.frac = frac;
    return r;
  endfunction

endpackage

// File: rtl/fp_norm_classify.sv
// Stage-2 combinational classification (zero / overflow / underflow / normal) and packing.
// FPNORM_DENORM_EN selects gradual underflow instead of flush-to-zero.
module fp_norm_classify
  import fp_pkg::*;
(
  input  logic                  sign,
  input  logic signed [EXP_W:0] exp,
  input  logic [S1_MANT_W-1:0]  mant,
  input  logic                  zero,
  output logic [31:0]           result,
  output logic [2:0]            flags
);

  fp32_t r;

`ifdef FPNORM_DENORM_EN
  logic signed [EXP_W:0] den_sh;
  logic [MANT_W-1:0]     den_frac;

  // exp <= 0 here, so the right-shift amount is always at least 1.
  always_comb begin
    den_sh   = 11'sd1 - exp;
    den_frac = '0;
    if (den_sh < 11'sd24) den_frac = mant >> den_sh[4:0];
  end
`endif

  always_comb begin
    r     = '0;
    flags = '0;
    if (zero) begin
      r               = fp_pack(sign, 8'h00, '0);
      flags[FLAG_ZERO] = 1'b1;
    end else if (exp >= 11'sd255) begin
      r              = fp_pack(sign, 8'hFF, '0);
      flags[FLAG_OVF] = 1'b1;
    end else if (exp <= 11'sd0) begin
      flags[FLAG_UNF] = 1'b1;
`ifdef FPNORM_DENORM_EN
      r               = fp_pack(sign, 8'h00, den_frac[FRAC_W-1:0]);
      flags[FLAG_ZERO] = (den_frac == '0);
`else
      r               = fp_pack(sign, 8'h00, '0);
      flags[FLAG_ZERO] = 1'b1;
`endif
    end else begin
      r = fp_pack(sign, exp[7:0], mant[FRAC_W-1:0]);
    end
  end

  assign result = r;

endmodule

// File: rtl/fp_norm_pack.sv
// Two-stage normalize-and-pack pipeline with valid/ready at both ends.
// Optional macro FPNORM_DENORM_EN enables denormal output instead of flush-to-zero.
module fp_norm_pack
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [4:0]        in_lzc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [2:0]        out_flags
);

  logic                  s1_valid;
  logic                  s1_sign;
  logic                  s1_zero;
  logic signed [EXP_W:0] s1_exp;
  logic [S1_MANT_W-1:0]  s1_mant;

  logic                  s2_valid;
  logic [31:0]           s2_result;
  logic [2:0]            s2_flags;

  logic                  in_fire;
  logic                  s2_load;
  logic signed [EXP_W:0] exp_adj;
  logic [31:0]           cls_result;
  logic [2:0]            cls_flags;

  assign in_ready = !s1_valid || !s2_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid && (!s2_valid || out_ready);

  // 11-bit signed subtract: range -543..511 cannot wrap.
  assign exp_adj = $signed({in_exp[EXP_W-1], in_exp}) - $signed({6'b0, in_lzc});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_sign  <= in_sign;
        s1_zero  <= (in_mant == '0);
        s1_exp   <= exp_adj;
        s1_mant  <= in_mant[S1_MANT_W-1:0] << in_lzc;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  fp_norm_classify u_classify (
    .sign   (s1_sign),
    .exp    (s1_exp),
    .mant   (s1_mant),
    .zero   (s1_zero),
    .result (cls_result),
    .flags  (cls_flags)
  );

  // Output register only changes when empty or being consumed, so it holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
    end else begin
      if (s2_load) begin
        s2_valid  <= 1'b1;
        s2_result <= cls_result;
        s2_flags  <= cls_flags;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_flags  = s2_flags;

endmodule

// File: tb/tb_fp_norm_pack.sv
// Self-checking bench for fp_norm_pack: directed vectors, backpressure, reset flush and
// randomized traffic against an arithmetic reference model and an in-order scoreboard.
module tb_fp_norm_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [23:0] in_mant;
  logic [4:0]  in_lzc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  fp_norm_pack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_lzc     (in_lzc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [34:0] exp_q[$];
  logic        last_acc;
  logic        prev_stall;
  logic [34:0] prev_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: straight from the arithmetic rules, result in {result[31:0], flags[2:0]}.
  function automatic logic [34:0] model(input logic s, input logic [9:0] e,
                                        input logic [23:0] m, input logic [4:0] l);
    int          ee;
    logic [23:0] mm;
    ee = int'($signed(e)) - int'(l);
    mm = m << l;
    if (m == 24'd0) return {s, 31'd0, 3'b001};
    if (ee >= 255)  return {s, 8'hFF, 23'd0, 3'b100};
    if (ee <= 0) begin
`ifdef FPNORM_DENORM_EN
      int          sh;
      logic [23:0] f;
      sh = 1 - ee;
      f  = (sh >= 24) ? 24'd0 : (mm >> sh);
      return {s, 8'h00, f[22:0], 1'b0, 1'b1, (f == 24'd0)};
`else
      return {s, 31'd0, 3'b011};
`endif
    end
    return {s, 8'(ee), mm[22:0], 3'b000};
  endfunction

  task automatic gen(output logic s, output logic [9:0] e, output logic [23:0] m,
                     output logic [4:0] l);
    int msb;
    s = 1'($urandom);
    if ($urandom_range(0, 1) == 1) e = 10'($urandom_range(0, 300));
    else                           e = 10'($urandom);
    if ($urandom_range(0, 7) == 0) begin
      m = 24'd0;
      l = 5'($urandom_range(0, 31));
    end else begin
      msb = $urandom_range(0, 23);
      m   = (24'h1 << msb) | (24'($urandom) & ((24'h1 << msb) - 24'h1));
      l   = 5'(23 - msb);
    end
  endtask

  // Called #0 after the falling edge once inputs are set; samples well before the rising edge.
  task automatic cycle_check(input string tag);
    #1;
    if (prev_stall) check({tag, "_stable"}, 64'({out_valid, out_result, out_flags}),
                          64'({1'b1, prev_out}));
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check({tag, "_unexpected_out"}, 64'(1), 64'(0));
      else check({tag, "_out"}, 64'({out_result, out_flags}), 64'(exp_q.pop_front()));
    end
    last_acc = in_valid && in_ready;
    if (last_acc) exp_q.push_back(model(in_sign, in_exp, in_mant, in_lzc));
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_result, out_flags};
  endtask

  task automatic run_vec(input string tag, input logic s, input logic [9:0] e,
                         input logic [23:0] m, input logic [4:0] l,
                         input logic [31:0] want_res, input logic [2:0] want_flags);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_lzc = l;
    #1 check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    check({tag, "_lat2_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_result"}, 64'(out_result), 64'(want_res));
    check({tag, "_flags"}, 64'(out_flags), 64'(want_flags));
  endtask

  initial begin
    logic [3:0][34:0] unused_beats;
    logic        s;
    logic [9:0]  e;
    logic [23:0] m;
    logic [4:0]  l;
    int          sent;
    int          base;
    int          seen;

    rst_n = 1'b0;
    in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; in_lzc = '0;
    out_ready = 1'b0;
    last_acc = 1'b0; prev_stall = 1'b0; prev_out = '0;
    unused_beats = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_result", 64'(out_result), 64'(0));
    check("rst_out_flags", 64'(out_flags), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;

    run_vec("one",      1'b0, 10'd127, 24'h800000, 5'd0,  32'h3F800000, 3'b000);
    run_vec("lzc23",    1'b0, 10'd150, 24'h000001, 5'd23, 32'h3F800000, 3'b000);
    run_vec("zero",     1'b1, 10'd200, 24'h000000, 5'd7,  32'h80000000, 3'b001);
    run_vec("ovf",      1'b1, 10'd300, 24'h800000, 5'd0,  32'hFF800000, 3'b100);
`ifdef FPNORM_DENORM_EN
    run_vec("unf",      1'b0, 10'd1,   24'h200000, 5'd2,  32'h00200000, 3'b010);
`else
    run_vec("unf",      1'b0, 10'd1,   24'h200000, 5'd2,  32'h00000000, 3'b011);
`endif
    run_vec("ovf_edge", 1'b0, 10'd255, 24'h800000, 5'd0,  32'h7F800000, 3'b100);
    run_vec("max_norm", 1'b0, 10'd254, 24'hFFFFFF, 5'd0,  32'h7F7FFFFF, 3'b000);

    // Backpressure: four back-to-back beats, output stalled for the first five cycles.
    @(negedge clk);
    exp_q.delete();
    prev_stall = 1'b0;
    base = n_out;
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      in_valid = (sent < 4);
      if (sent < 4) begin
        gen(s, e, m, l);
        in_sign = s; in_exp = e; in_mant = m; in_lzc = l;
      end
      out_ready = (c >= 5);
      cycle_check("bp");
      if (c == 2) begin
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        check("bp_sent_before_stall", 64'(sent), 64'(2));
      end
      if (last_acc) sent++;
      if (sent == 4 && exp_q.size() == 0) break;
    end
    check("bp_count_out", 64'(n_out - base), 64'(4));
    check("bp_queue_empty", 64'(exp_q.size()), 64'(0));

    // Reset with two beats in flight.
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    prev_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      gen(s, e, m, l);
      in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = 24'h800000; in_lzc = 5'd0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("rf_valid_before", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rf_out_valid", 64'(out_valid), 64'(0));
    check("rf_out_result", 64'(out_result), 64'(0));
    check("rf_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rf_nothing_after", 64'(seen), 64'(0));

    // Randomized traffic with random backpressure.
    exp_q.delete();
    prev_stall = 1'b0;
    last_acc = 1'b0;
    in_valid = 1'b0;
    base = n_out;
    sent = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        gen(s, e, m, l);
        in_sign = s; in_exp = e; in_mant = m; in_lzc = l;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle_check("rnd");
      if (last_acc) sent++;
    end
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      cycle_check("drain");
    end
    check("rnd_drain_empty", 64'(exp_q.size()), 64'(0));
    check("rnd_count_out", 64'(n_out - base), 64'(sent));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
